// File: rtl/pbit_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : pbit_sweeper
//  Description : Sequential Gibbs sweeper for a p-bit array. Updates one bit
//                per cycle from an external local field and an LFSR noise draw.
//  Revision    : 1.0 - initial release
// ============================================================================
module pbit_sweeper #(
    parameter int          PBITS      = 8,
    parameter int          BETA_SHIFT = 4,
    parameter logic [31:0] SEED       = 32'hACE1_2024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         sweeps,
    input  logic signed [31:0]  field_in,
    output logic [PBITS-1:0]    state,
    output logic signed [31:0]  index,
    output logic                busy,
    output logic                done,
    output logic [31:0]         flip_count
);

    localparam logic [1:0]         c_IDLE = 2'd0;
    localparam logic [1:0]         c_RUN  = 2'd1;
    localparam logic [1:0]         c_DONE = 2'd2;
    localparam logic [31:0]        c_TAPS = 32'h8020_0003;
    localparam logic [31:0]        c_SEED = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic signed [31:0] c_LAST = PBITS - 1;

    logic [1:0]         r_fsm;
    logic [1:0]         w_fsm_nxt;
    logic [PBITS-1:0]   r_state;
    logic signed [31:0] r_index;
    logic [31:0]        r_flip;
    logic [31:0]        r_lfsr;
    logic [15:0]        r_sweeps_left;

    logic signed [31:0] w_rnd;
    logic               w_newbit;
    logic               w_cur_bit;
    logic [PBITS-1:0]   w_state_upd;
    logic [31:0]        w_lfsr_nxt;
    logic               w_wrap;
    logic               w_last_update;

    assign w_wrap        = (r_index == c_LAST);
    assign w_last_update = w_wrap && (r_sweeps_left == 16'd1);

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            c_IDLE: if (start) w_fsm_nxt = (sweeps != 16'd0) ? c_RUN : c_DONE;
            c_RUN:  if (w_last_update) w_fsm_nxt = c_DONE;
            c_DONE: w_fsm_nxt = c_IDLE;
            default: w_fsm_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= c_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    // Strict compare: a field equal to the noise sample yields 0.
    always_comb begin
        w_rnd       = $signed(r_lfsr) >>> BETA_SHIFT;
        w_newbit    = (field_in > w_rnd);
        w_cur_bit   = 1'b0;
        w_state_upd = r_state;
        for (int i = 0; i < PBITS; i++) begin
            if (r_index == i) begin
                w_cur_bit      = r_state[i];
                w_state_upd[i] = w_newbit;
            end
        end
        w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_TAPS) : (r_lfsr >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= '0;
            r_index       <= -32'sd1;
            r_flip        <= '0;
            r_lfsr        <= c_SEED;
            r_sweeps_left <= '0;
        end else begin
            case (r_fsm)
                c_IDLE: begin
                    if (start) begin
                        r_flip <= '0;
                        if (sweeps != 16'd0) begin
                            r_sweeps_left <= sweeps;
                            r_index       <= 32'sd0;
                        end
                    end
                end
                c_RUN: begin
                    r_state <= w_state_upd;
                    r_lfsr  <= w_lfsr_nxt;
                    if ((w_cur_bit != w_newbit) && (r_flip != 32'hFFFF_FFFF))
                        r_flip <= r_flip + 32'd1;
                    if (w_wrap) begin
                        r_sweeps_left <= r_sweeps_left - 16'd1;
                        r_index       <= w_last_update ? -32'sd1 : 32'sd0;
                    end else begin
                        r_index <= r_index + 32'sd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state      = r_state;
    assign index      = r_index;
    assign busy       = (r_fsm == c_RUN);
    assign done       = (r_fsm == c_DONE);
    assign flip_count = r_flip;

endmodule
`default_nettype wire

// File: doc/pbit_sweeper.md
PBIT_SWEEPER -- requirements
Module: pbit_sweeper

Interface
REQ-001 Parameters: PBITS, default 8, number of p-bits, 1..1024.
REQ-002 Parameters: BETA_SHIFT, default 4, arithmetic right shift of the random sample (inverse temperature), 1..31.
REQ-003 Parameters: SEED, default 32'hACE1_2024, LFSR reset value; a value of 0 is replaced by 32'h1.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  run request, sampled only in IDLE.
REQ-007 Port sweeps  input  16  number of full sweeps for the run, sampled with start.
REQ-008 Port field_in  input  32 signed  local field from the conv stage for the current index, combinational.
REQ-009 Port state  output  PBITS  p-bit register, fed to the conv stage.
REQ-010 Port index  output  32 signed  bit under update, fed to the conv stage; -1 when not updating.
REQ-011 Port busy  output  1  high while in RUN.
REQ-012 Port done  output  1  one-cycle pulse marking the end of a run.
REQ-013 Port flip_count  output  32  count of state-bit changes in the current or last run.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, with transitions IDLE->RUN, RUN->DONE and DONE->IDLE.
REQ-015 IDLE with start=1 and sweeps!=0 SHALL go to RUN on the edge, latch sweeps, clear flip_count, and set index to 0.
REQ-016 IDLE with start=1 and sweeps=0 SHALL go to DONE with no bit updated and flip_count cleared.
REQ-017 RUN SHALL update exactly one bit per cycle at each edge, as follows:
  - rnd = $signed(lfsr) >>> BETA_SHIFT;
  - state[index] <= (field_in > rnd) (strict compare; equality gives 0);
  - flip_count increments if the bit changes;
  - the LFSR advances one step.
REQ-018 The LFSR SHALL be a 32-bit Galois LFSR with taps 32'h8020_0003 that shifts right and XORs the taps when the LSB is 1; it SHALL advance only on RUN updates.
REQ-019 Index SHALL walk 0,1,...,PBITS-1 and then wrap to 0, decrementing the sweep counter at each wrap.
REQ-020 The update of index PBITS-1 in the final sweep SHALL move the FSM to DONE and set index to -1; one run lasts exactly sweeps*PBITS RUN cycles.
REQ-021 DONE SHALL assert done=1 for one cycle and then go to IDLE; busy SHALL be 0 in DONE and IDLE.
REQ-022 start SHALL be ignored in RUN and DONE, with no queuing.
REQ-023 Outside RUN, index SHALL equal -1 so that the conv stage sums only set bits.
REQ-024 state and flip_count SHALL hold their values in IDLE and DONE.
REQ-025 flip_count SHALL saturate at 32'hFFFF_FFFF.
REQ-026 field_in SHALL be used in the same cycle index is driven; the path index->conv->field_in->state is single-cycle and registers no field value.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force:
  - FSM to IDLE;
  - state=0;
  - index=-1;
  - busy=0, done=0;
  - flip_count=0;
  - lfsr=SEED (or 1 if SEED=0);
  - sweep counter=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after deassertion SHALL begin a fresh run.

Verification
REQ-029 PBITS=4, field_in held at 32'h7FFF_FFFF, start with sweeps=1 -> index 0,1,2,3 on four consecutive cycles; state=4'b1111; done pulses on the 5th cycle after the start edge; flip_count=4.
REQ-030 Following REQ-029, field_in held at 32'h8000_0000, sweeps=2 -> state=4'b0000; flip_count=4; busy high for exactly 8 cycles; index=-1 when done is high.
REQ-031 start with sweeps=0 -> done on the next cycle; busy never high; state, LFSR and index=-1 unchanged; flip_count=0.
REQ-032 PBITS=4, sweeps=3, start held high throughout the run -> exactly one done pulse, after 12 busy cycles; the second run begins only from IDLE.
REQ-033 rst pulsed during cycle 2 of a run -> all outputs take their reset values with no clock edge; no done pulse; a rerun with SEED and field_in=0 reproduces bit-exactly the state sequence of an uninterrupted run.
REQ-034 SEED=0 with field_in=0 over 64 updates -> the LFSR never reaches 0 and the state sequence matches a golden model seeded with 1.
